// File: rtl/lfsr_pkg.sv
// lfsr_pkg: state encoding, default LFSR width and a constant clog2 helper
// shared by the range sampler and its FIFO.
`default_nettype none

package lfsr_pkg;

  localparam int LFSR_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// sample_fifo: show-ahead synchronous FIFO; head always presents the oldest entry.
// Push is refused while full and pop while empty, so count stays in 0..DEPTH.
`default_nettype none

module sample_fifo
  import lfsr_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full refuses a push even when a pop lands in the same cycle.
  assign w_push  = push & ~w_full;
  assign w_pop   = pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/lfsr_range_sampler.sv
// lfsr_range_sampler: rejection-samples LFSR words into [0, RANGE-1] with a
// bounded retry count and queues accepted values in a show-ahead FIFO.
`default_nettype none

module lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter  int WIDTH     = LFSR_WIDTH,
  parameter  int RANGE     = 160,
  parameter  int DEPTH     = 4,
  parameter  int MAX_TRIES = 8,
  localparam int M         = clog2(RANGE),
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lfsr_data,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [M-1:0]     out_value,
  output logic [CW-1:0]    fifo_count,
  output logic [7:0]       fallback_cnt
);

  localparam int         TW       = clog2(MAX_TRIES) + 1;
  localparam logic [M:0] RANGE_M1 = (M + 1)'(RANGE);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_try;
  logic [7:0]    r_fallback;

  logic [M-1:0]  w_s;
  logic [M-1:0]  w_fold;
  logic [M-1:0]  w_data;
  logic [M-1:0]  w_head;
  logic          w_in_range;
  logic          w_last_try;
  logic          w_sampling;
  logic          w_accept;
  logic          w_forced;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_next_count;

  generate
    if (WIDTH > M) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^lfsr_data[WIDTH-1:M];
    end
  endgenerate

  assign w_s        = lfsr_data[M-1:0];
  assign w_in_range = ({1'b0, w_s} < RANGE_M1);
  // 2**M < 2*RANGE, so one subtraction always lands back in range.
  assign w_fold     = w_s - RANGE_M1[M-1:0];
  assign w_last_try = (r_try == TW'(MAX_TRIES - 1));
  assign w_sampling = (r_state == ST_FILL) & en;
  assign w_accept   = w_sampling & (w_in_range | w_last_try);
  assign w_forced   = w_sampling & ~w_in_range & w_last_try;
  assign w_data     = w_in_range ? w_s : w_fold;

  assign w_push       = w_accept & (fifo_count != CW'(DEPTH));
  assign w_pop        = out_valid & out_ready;
  assign w_next_count = fifo_count + CW'(w_push) - CW'(w_pop);

  sample_fifo #(
    .DW    (M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (!en)                                w_state_nxt = ST_IDLE;
        else if (w_next_count == CW'(DEPTH))    w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!en)                                w_state_nxt = ST_IDLE;
        else if (w_next_count < CW'(DEPTH))     w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_try      <= '0;
      r_fallback <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Outside active sampling (IDLE, HOLD, en low) the retry budget is refreshed.
      if (!w_sampling || w_accept) r_try <= '0;
      else                         r_try <= r_try + TW'(1);
      if (w_forced && r_fallback != 8'hFF) r_fallback <= r_fallback + 8'd1;
    end
  end

  assign out_valid    = (fifo_count != '0);
  assign out_value    = out_valid ? w_head : '0;
  assign fallback_cnt = r_fallback;

endmodule

`default_nettype wire
